// File: rtl/fetch_sequencer_if.sv
// Bundles the loader handshake, fetch control, instruction-memory bus and
// decode-side fetch outputs of the fetch sequencer into one port.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 9
);
  logic              load_valid;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic              load_ready;
  logic              start;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic              halt_req;
  logic [31:0]       imem_addr;
  logic              imem_we;
  logic [31:0]       imem_wdata;
  logic [31:0]       imem_rdata;
  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic [31:0]       if_instr;
  logic [1:0]        state;
  logic [31:0]       fetch_count;

  // Sequencer side.
  modport master (
    input  load_valid, load_addr, load_data,
    output load_ready,
    input  start, stall, redirect_valid, redirect_target, halt_req,
    output imem_addr, imem_we, imem_wdata,
    input  imem_rdata,
    output if_valid, if_pc, if_instr, state, fetch_count
  );

  // Environment side: loader, pipeline control, memory and decode.
  modport slave (
    output load_valid, load_addr, load_data,
    input  load_ready,
    output start, stall, redirect_valid, redirect_target, halt_req,
    input  imem_addr, imem_we, imem_wdata,
    output imem_rdata,
    input  if_valid, if_pc, if_instr, state, fetch_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, shares the instruction memory between the
// boot loader (IDLE only) and instruction fetch (RUN), and presents fetched
// words to decode through a registered valid/pc/instr stage.
module fetch_sequencer #(
  parameter int          ADDR_W   = 9,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              if_valid_q, if_valid_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [31:0]       if_instr_q, if_instr_d;
  logic [31:0]       fetch_count_q, fetch_count_d;
  logic              load_ready;

  // Next-state: redirect beats stall beats fetch; halt_req lets the cycle's
  // action finish and then parks the sequencer.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      ST_IDLE: begin
        if_valid_d = 1'b0;
        if (bus.start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.redirect_valid) begin
          // The word read this cycle is on the wrong path: drop it.
          pc_d       = bus.redirect_target;
          if_valid_d = 1'b0;
        end else if (!bus.stall) begin
          if_instr_d    = bus.imem_rdata;
          if_pc_d       = pc_q;
          if_valid_d    = 1'b1;
          pc_d          = pc_q + ADDR_W'(1);
          fetch_count_d = fetch_count_q + 32'd1;
        end
        if (bus.halt_req) state_d = ST_HALT;
      end
      ST_HALT: begin
        if_valid_d = 1'b0;
        if (bus.start) state_d = ST_RUN;
      end
      default: begin
        // Unused encoding: fall back to IDLE.
        state_d    = ST_IDLE;
        if_valid_d = 1'b0;
      end
    endcase
  end

  // State and fetch-stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC_W;
      if_valid_q    <= 1'b0;
      if_pc_q       <= '0;
      if_instr_q    <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Memory port steering: loader owns the port in IDLE, the PC otherwise.
  always_comb begin
    load_ready     = !reset && (state_q == ST_IDLE);
    bus.load_ready = load_ready;
    bus.imem_we    = load_ready && bus.load_valid;
    bus.imem_wdata = (load_ready && bus.load_valid) ? bus.load_data : 32'd0;
    if (state_q == ST_IDLE) bus.imem_addr = 32'(bus.load_addr);
    else                    bus.imem_addr = 32'(pc_q);
  end

  assign bus.if_valid    = if_valid_q;
  assign bus.if_pc       = if_pc_q;
  assign bus.if_instr    = if_instr_q;
  assign bus.state       = state_q;
  assign bus.fetch_count = fetch_count_q;

endmodule
